pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_next_mux.sv | 33 +++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared processor package: FSM state encoding, PC width, reset address
// and the word-to-byte shift used by branch and jump targets.
package pc_sequencer_pkg;

    localparam int PC_W     = 32;
    localparam int BR_SHIFT = 2;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_t;

    // Sign-extend a 16-bit word offset to the PC width.
    function automatic logic [PC_W-1:0] sext16(input logic [15:0] v);
        return {{(PC_W-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection. Jump beats branch, and branch beats fall-through.
// All arithmetic wraps silently modulo 2^32.
module pc_next_mux
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [15:0] Imm,
    input  logic [25:0] JTarget,
    input  logic        PCSrc,
    input  logic        Jump,
    output logic [31:0] NextPC
);

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;

    assign pc_plus4      = PC + 32'd4;
    assign branch_target = pc_plus4 + (sext16(Imm) << BR_SHIFT);
    // Jump keeps the 256 MB region of the fall-through address.
    assign jump_target   = {pc_plus4[PC_W-1:PC_W-4], JTarget, {BR_SHIFT{1'b0}}};

    // Priority select of the next fetch address.
    always_comb begin
        NextPC = pc_plus4;
        if (Jump) begin
            NextPC = jump_target;
        end else if (PCSrc) begin
            NextPC = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC loop with a saturating
// taken-branch counter.
//
// Fetch handshake: FetchReq is held high for every cycle spent in FETCH; the
// request completes on the rising edge where FetchReq && FetchAck are both 1,
// and the FSM then moves to EXEC. FetchReq must not depend on FetchAck and PC
// stays stable while the request is pending.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCSrc,
    input  logic             Jump,
    input  logic [15:0]      Imm,
    input  logic [25:0]      JTarget,
    input  logic             Stall,
    input  logic             FetchAck,
    output logic             FetchReq,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus4,
    output logic             InstrValid,
    output logic [CNT_W-1:0] BranchCount
);

    seq_state_t      state;
    seq_state_t      state_next;
    logic            pc_load;
    logic            br_inc;
    logic [PC_W-1:0] next_pc;

    assign PCPlus4 = PC + 32'd4;

    pc_next_mux u_next (
        .PC      (PC),
        .Imm     (Imm),
        .JTarget (JTarget),
        .PCSrc   (PCSrc),
        .Jump    (Jump),
        .NextPC  (next_pc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state outputs; branch inputs only matter when EXEC retires.
    always_comb begin
        state_next = state;
        FetchReq   = 1'b0;
        InstrValid = 1'b0;
        pc_load    = 1'b0;
        br_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                FetchReq = 1'b1;
                if (FetchAck) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                InstrValid = 1'b1;
                if (!Stall) begin
                    state_next = ST_FETCH;
                    pc_load    = 1'b1;
                    br_inc     = PCSrc & ~Jump;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Program counter: loads only when an instruction retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC <= RESET_PC;
        end else if (pc_load) begin
            PC <= next_pc;
        end
    end

    // Taken-branch counter, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCount <= '0;
        end else if (br_inc && (BranchCount != {CNT_W{1'b1}})) begin
            BranchCount <= BranchCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, all checked
// against a cycle-level reference model. A second instance with a 4-bit
// counter shares the stimulus so saturation is reached in a short run.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        PCSrc;
    logic        Jump;
    logic [15:0] Imm;
    logic [25:0] JTarget;
    logic        Stall;
    logic        FetchAck;

    logic        FetchReq;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic [15:0] BranchCount;

    logic        freq_b;
    logic [31:0] pc_b;
    logic [31:0] pc4_b;
    logic        iv_b;
    logic [3:0]  cnt_b;

    int n_tests;
    int n_fail;

    // Reference model: phase 0 = idle, 1 = fetching, 2 = executing.
    int          m_phase;
    logic [31:0] m_pc;
    int          m_cnt;
    int          m_cnt4;

    logic [31:0] exp_q[$];

    pc_sequencer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSrc       (PCSrc),
        .Jump        (Jump),
        .Imm         (Imm),
        .JTarget     (JTarget),
        .Stall       (Stall),
        .FetchAck    (FetchAck),
        .FetchReq    (FetchReq),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .InstrValid  (InstrValid),
        .BranchCount (BranchCount)
    );

    pc_sequencer #(.CNT_W(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSrc       (PCSrc),
        .Jump        (Jump),
        .Imm         (Imm),
        .JTarget     (JTarget),
        .Stall       (Stall),
        .FetchAck    (FetchAck),
        .FetchReq    (freq_b),
        .PC          (pc_b),
        .PCPlus4     (pc4_b),
        .InstrValid  (iv_b),
        .BranchCount (cnt_b)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 32'h0000_0000;
        m_cnt   = 0;
        m_cnt4  = 0;
    endtask

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc);
        logic [31:0] seq;
        logic [31:0] off;
        seq = pc + 32'd4;
        off = {{16{Imm[15]}}, Imm};
        if (Jump)       return {seq[31:28], JTarget, 2'b00};
        else if (PCSrc) return seq + off * 32'd4;
        else            return seq;
    endfunction

    task automatic compare_all();
        check("pc",       PC,          m_pc);
        check("pc4",      PCPlus4,     m_pc + 32'd4);
        check("freq",     {31'd0, FetchReq},   {31'd0, m_phase == 1});
        check("ivalid",   {31'd0, InstrValid}, {31'd0, m_phase == 2});
        check("excl",     {31'd0, FetchReq & InstrValid}, 32'd0);
        check("cnt",      {16'd0, BranchCount}, 32'(m_cnt));
        check("pc_b",     pc_b,        m_pc);
        check("pc4_b",    pc4_b,       m_pc + 32'd4);
        check("freq_b",   {31'd0, freq_b}, {31'd0, m_phase == 1});
        check("ivalid_b", {31'd0, iv_b},   {31'd0, m_phase == 2});
        check("cnt4",     {28'd0, cnt_b},  32'(m_cnt4));
    endtask

    // One clock: predict from the current model and inputs, then compare.
    task automatic tick();
        int          n_phase;
        logic [31:0] n_pc;
        int          n_cnt;
        int          n_cnt4;
        n_phase = m_phase;
        n_pc    = m_pc;
        n_cnt   = m_cnt;
        n_cnt4  = m_cnt4;
        if (rst_n) begin
            case (m_phase)
                0: n_phase = 1;
                1: if (FetchAck) n_phase = 2;
                default: begin
                    if (!Stall) begin
                        n_phase = 1;
                        n_pc    = model_next_pc(m_pc);
                        if (PCSrc && !Jump) begin
                            n_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
                            n_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
                        end
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        m_phase = n_phase;
        m_pc    = n_pc;
        m_cnt   = n_cnt;
        m_cnt4  = n_cnt4;
        compare_all();
    endtask

    task automatic idle_inputs();
        PCSrc    = 1'b0;
        Jump     = 1'b0;
        Imm      = 16'h0000;
        JTarget  = 26'h0;
        Stall    = 1'b0;
        FetchAck = 1'b1;
    endtask

    // Advance until the model says an instruction is executing (bounded).
    task automatic run_to_exec();
        idle_inputs();
        for (int i = 0; i < 4 && m_phase != 2; i++) tick();
        check("reach_exec", {31'd0, InstrValid}, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1 compare_all();
        tick();
        tick();
        rst_n = 1'b1;

        // Straight-line fetch/execute: PCs 0,4,8,12 on EXEC cycles.
        for (int i = 0; i < 8; i++) begin
            tick();
            if (InstrValid) exp_q.push_back(PC);
        end
        check("seq_len", 32'(exp_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < exp_q.size(); i++)
            check("seq_pc", exp_q[i], 32'(i * 4));

        // Jump to 0x100, then backward branch to 0x0FC.
        run_to_exec();
        Jump = 1'b1; JTarget = 26'h0000040;
        tick();
        check("jmp_pc", PC, 32'h0000_0100);
        run_to_exec();
        PCSrc = 1'b1; Imm = 16'hFFFE;
        tick();
        check("br_pc", PC, 32'h0000_00FC);
        check("br_cnt", {16'd0, BranchCount}, 32'd1);

        // FetchAck low for 3 cycles, branch inputs ignored while fetching.
        idle_inputs();
        FetchAck = 1'b0; PCSrc = 1'b1; Jump = 1'b1; JTarget = 26'h3FFFFFF;
        for (int i = 0; i < 3; i++) tick();
        check("ack_hold_pc", PC, 32'h0000_00FC);
        check("ack_hold_req", {31'd0, FetchReq}, 32'd1);
        FetchAck = 1'b1; PCSrc = 1'b0; Jump = 1'b0;
        tick();
        // Stall for 3 cycles with a taken branch pending.
        Stall = 1'b1; PCSrc = 1'b1; Imm = 16'h0040;
        for (int i = 0; i < 3; i++) tick();
        check("stall_pc", PC, 32'h0000_00FC);
        check("stall_cnt", {16'd0, BranchCount}, 32'd1);
        check("stall_iv", {31'd0, InstrValid}, 32'd1);
        Stall = 1'b0; PCSrc = 1'b0;
        tick();

        // Wrap: jump to 0, branch back to 0xFFFFFFFC, fall through to 0.
        run_to_exec();
        Jump = 1'b1; JTarget = 26'h0;
        tick();
        run_to_exec();
        PCSrc = 1'b1; Imm = 16'hFFFE;
        tick();
        check("wrap_pc", PC, 32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4, 32'h0000_0000);
        run_to_exec();
        tick();
        check("wrap_next", PC, 32'h0000_0000);

        // Climb to 0x1000_0000 with maximal forward branches (0x20000 each).
        for (int i = 0; i < 2048; i++) begin
            run_to_exec();
            PCSrc = 1'b1; Imm = 16'h7FFF;
            tick();
        end
        check("climb_pc", PC, 32'h1000_0000);
        check("climb_cnt", {16'd0, BranchCount}, 32'd2050);
        check("sat_cnt4", {28'd0, cnt_b}, 32'h0000_000F);

        // Jump beats branch and does not count.
        run_to_exec();
        Jump = 1'b1; PCSrc = 1'b1; JTarget = 26'h0000040;
        tick();
        check("jb_pc", PC, 32'h1000_0100);
        check("jb_cnt", {16'd0, BranchCount}, 32'd2050);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            PCSrc    = 1'($urandom_range(0, 1));
            Jump     = ($urandom_range(0, 3) == 0);
            Imm      = 16'($urandom);
            JTarget  = 26'($urandom);
            Stall    = ($urandom_range(0, 3) == 0);
            FetchAck = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Reset mid-EXEC with a taken branch presented.
        run_to_exec();
        PCSrc = 1'b1; Imm = 16'h0100;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pc", PC, 32'h0000_0000);
        check("rst_cnt", {16'd0, BranchCount}, 32'd0);
        check("rst_freq", {31'd0, FetchReq}, 32'd0);
        check("rst_iv", {31'd0, InstrValid}, 32'd0);
        tick();
        rst_n = 1'b1;
        PCSrc = 1'b0;
        tick();
        check("rst_fetch", {31'd0, FetchReq}, 32'd1);
        tick();
        check("rst_exec_pc", PC, 32'h0000_0000);
        check("rst_exec_iv", {31'd0, InstrValid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
